// File: rtl/shift_mult_32_pkg.sv
// rtl/shift_mult_32_pkg.sv - shared multiplier definitions (state encodings, width, last iteration)
package shift_mult_32_pkg;

   localparam int MULT_WIDTH = 32;
   localparam int MULT_CNT_W = 5;
   localparam logic [4:0] MULT_LAST = 5'd31;

   // Encodings are shared with the control FSM, so they must not be renumbered.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FAST = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;

endpackage

// File: rtl/shift_mult_32_onehot_enc.sv
// rtl/shift_mult_32_onehot_enc.sv - onehot_enc_32: 32->5 bit-position encoder for a one-hot word, 0 for zero input
module onehot_enc_32 (
   input  logic [31:0] onehot,
   output logic [4:0]  idx
);

   // OR-ing positions is exact for a one-hot word and yields 0 for an all-zero word.
   always_comb begin
      idx = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (onehot[i]) idx = idx | i[4:0];
      end
   end

endmodule

// File: rtl/shift_mult_32.sv
// rtl/shift_mult_32.sv - multi-cycle unsigned 32x32->64 multiplier; SHIFT_MULT_FAST_PATH_EN enables the 1-cycle power-of-two path
module shift_mult_32
   import shift_mult_32_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = MULT_CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   onehot_b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod
);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH:0]   upper;

   // Shift-add step: the multiplier occupies prod's low half and drains out as the sum shifts in.
   always_comb begin
      upper = {1'b0, prod[2*WIDTH-1:WIDTH]};
      if (prod[0]) upper = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
   end

`ifdef SHIFT_MULT_FAST_PATH_EN
   logic [WIDTH-1:0]   oh_q;
   logic               b_zero_q;
   logic [4:0]         idx;
   logic [2*WIDTH-1:0] fast_prod;

   onehot_enc_32 u_enc (
      .onehot (oh_q),
      .idx    (idx)
   );

   assign fast_prod = b_zero_q ? '0 : ({{WIDTH{1'b0}}, a_q} << idx);
`else
   logic unused_onehot;
   assign unused_onehot = ^onehot_b;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         prod  <= '0;
         cnt   <= '0;
         a_q   <= '0;
`ifdef SHIFT_MULT_FAST_PATH_EN
         oh_q     <= '0;
         b_zero_q <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q  <= a;
                  busy <= 1'b1;
`ifdef SHIFT_MULT_FAST_PATH_EN
                  oh_q     <= onehot_b;
                  b_zero_q <= (b == '0);
                  if (onehot_b != '0 || b == '0) begin
                     state <= S_FAST;
                  end else begin
                     state <= S_ITER;
                     prod  <= {{WIDTH{1'b0}}, b};
                     cnt   <= '0;
                  end
`else
                  state <= S_ITER;
                  prod  <= {{WIDTH{1'b0}}, b};
                  cnt   <= '0;
`endif
               end
            end
`ifdef SHIFT_MULT_FAST_PATH_EN
            S_FAST: begin
               prod  <= fast_prod;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
`endif
            S_ITER: begin
               prod <= {upper, prod[WIDTH-1:1]};
               cnt  <= cnt + 1'b1;
               if (cnt == MULT_LAST) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_mult_32.sv
// tb/tb_shift_mult_32.sv - scoreboard bench for shift_mult_32 (expectations follow SHIFT_MULT_FAST_PATH_EN)
module tb_shift_mult_32;

   typedef struct {
      logic [63:0] prod;
      int          lat;
      int          start_cyc;
      string       name;
   } exp_t;

`ifdef SHIFT_MULT_FAST_PATH_EN
   localparam int FAST_LAT = 1;
`else
   localparam int FAST_LAT = 32;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [31:0] onehot_b = '0;
   logic        busy;
   logic        done;
   logic [63:0] prod;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   shift_mult_32 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .onehot_b (onehot_b),
      .busy     (busy),
      .done     (done),
      .prod     (prod)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: pops the oldest expectation at every done pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (busy && done) begin
            n_checks++;
            n_errors++;
            $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1", busy, done);
         end
         if (done) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_done: prod=%h with empty scoreboard", prod);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check64({e.name, "_prod"}, prod, e.prod);
               check_int({e.name, "_latency"}, cyc - e.start_cyc, e.lat);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((busy || sb.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_idle_timeout: busy=%b pending=%0d", busy, sb.size());
         sb.delete();
      end
   endtask

   // Drives one start pulse at a negedge; the following posedge is E0.
   task automatic issue(input string name, input logic [31:0] ta, input logic [31:0] tb,
                        input logic [31:0] toh, input logic [63:0] p, input int lat);
      exp_t e;
      wait_idle();
      @(negedge clk);
      a = ta; b = tb; onehot_b = toh; start = 1'b1;
      e.prod = p; e.lat = lat; e.start_cyc = cyc + 1; e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h1234_5678; onehot_b = 32'h0000_0100;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      repeat (3) @(negedge clk);
      check_int("reset_busy", int'(busy), 0);
      check_int("reset_done", int'(done), 0);
      check64("reset_prod", prod, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      issue("pow2_7x8", 32'd7, 32'd8, 32'd8, 64'd56, FAST_LAT);
      issue("ffx3", 32'hFFFF_FFFF, 32'd3, 32'd0, 64'h2_FFFF_FFFD, 32);
      issue("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 64'hFFFF_FFFE_0000_0001, 32);
      issue("pow2_2xmsb", 32'd2, 32'h8000_0000, 32'h8000_0000, 64'h1_0000_0000, FAST_LAT);
      issue("bzero", 32'd1234, 32'd0, 32'd0, 64'd0, FAST_LAT);
      issue("pow2_1x1", 32'd1, 32'd1, 32'd1, 64'd1, FAST_LAT);
      issue("azero", 32'd0, 32'd7, 32'd0, 64'd0, 32);
      issue("13x11", 32'd13, 32'd11, 32'd0, 64'd143, 32);
      wait_idle();

      // Abort mid-iteration: no partial result may survive.
      issue("abort", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 64'hFFFF_FFFE_0000_0001, 32);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_int("abort_busy", int'(busy), 0);
      check_int("abort_done", int'(done), 0);
      check64("abort_prod", prod, 64'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      issue("after_abort_5x6", 32'd5, 32'd6, 32'd0, 64'd30, 32);
      wait_idle();

      // start held high: first op must not restart, second begins in the done cycle.
      @(negedge clk);
      a = 32'd3; b = 32'd5; onehot_b = 32'd0; start = 1'b1;
      e.prod = 64'd15; e.lat = 32; e.start_cyc = cyc + 1; e.name = "held_first";
      sb.push_back(e);
      e.prod = 64'd90; e.lat = 32; e.start_cyc = cyc + 34; e.name = "held_second";
      sb.push_back(e);
      @(posedge clk);
      #1;
      a = 32'd9; b = 32'd10;
      repeat (33) @(posedge clk);
      #1;
      start = 1'b0;
      wait_idle();

      check_int("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
